// File: rtl/output_dev_pkg.sv
// Register offsets and CTRL bit positions shared by the output device and its users.
package output_dev_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_CTRL    = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_SCRATCH = 2'd3;

    localparam int CTRL_FREEZE = 0;
    localparam int CTRL_CLR    = 1;

endpackage

// File: rtl/output_dev.sv
// Memory-mapped output device: DATA/CTRL/STATUS/SCRATCH word registers behind the CPU bus.
// Optional macro OUTPUT_DEV_WCNT_EN turns STATUS into a count of accepted writes.
module output_dev
    import output_dev_pkg::*;
#(
    parameter int              DW      = 32,
    parameter logic [DW-1:0]   RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [3:2]    addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] scratch_q, scratch_d;
    logic          freeze_q, freeze_d;
    logic [DW-1:0] status;

    // CLR is a pulse: it only acts on DATA during the write, so it never needs storage.
    always_comb begin
        data_d    = data_q;
        scratch_d = scratch_q;
        freeze_d  = freeze_q;
        if (en) begin
            case (addr)
                ADDR_DATA: begin
                    if (!freeze_q) data_d = din;
                end
                ADDR_CTRL: begin
                    freeze_d = din[CTRL_FREEZE];
                    if (din[CTRL_CLR]) data_d = '0;
                end
                ADDR_SCRATCH: scratch_d = din;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= RST_VAL;
            scratch_q <= RST_VAL;
            freeze_q  <= 1'b0;
        end else begin
            data_q    <= data_d;
            scratch_q <= scratch_d;
            freeze_q  <= freeze_d;
        end
    end

`ifdef OUTPUT_DEV_WCNT_EN
    logic [DW-1:0] wcnt_q, wcnt_d;
    logic          wr_acc;

    // A frozen DATA write is dropped, so it is not counted either.
    assign wr_acc = en && (addr != ADDR_STATUS) && !((addr == ADDR_DATA) && freeze_q);

    always_comb begin
        wcnt_d = wcnt_q;
        if (wr_acc) wcnt_d = wcnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) wcnt_q <= '0;
        else     wcnt_q <= wcnt_d;
    end

    assign status = wcnt_q;
`else
    assign status = '0;
`endif

    always_comb begin
        dout = '0;
        case (addr)
            ADDR_DATA:    dout = data_q;
            ADDR_CTRL:    dout = {{(DW-1){1'b0}}, freeze_q};
            ADDR_STATUS:  dout = status;
            ADDR_SCRATCH: dout = scratch_q;
            default:      dout = '0;
        endcase
    end

endmodule

// File: tb/tb_output_dev.sv
// Directed self-checking bench for output_dev; expectations follow OUTPUT_DEV_WCNT_EN when defined.
module tb_output_dev;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:2]  addr;
    logic [31:0] din;
    logic [31:0] dout;

    int pass_cnt;
    int total_cnt;

`ifdef OUTPUT_DEV_WCNT_EN
    localparam bit WCNT = 1'b1;
`else
    localparam bit WCNT = 1'b0;
`endif

    output_dev #(.DW(32), .RST_VAL(32'h0)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .addr (addr),
        .din  (din),
        .dout (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        en   = 1'b1;
        addr = a;
        din  = d;
        tick();
        en   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; addr = 2'd0; din = 32'h0;
        tick();
        rst = 1'b0;
        for (int a = 0; a < 4; a++) begin
            addr = a[1:0];
            #1;
            total_cnt++;
            if (dout !== 32'h0) $display("FAIL reset_addr%0d got %h exp %h", a, dout, 32'h0);
            else pass_cnt++;
        end
    endtask

    task automatic test_data_write();
        wr(2'd0, 32'h1234_5678);
        addr = 2'd0; #1;
        total_cnt++;
        if (dout !== 32'h1234_5678) $display("FAIL data_write got %h exp %h", dout, 32'h1234_5678);
        else pass_cnt++;
        tick(); tick();
        total_cnt++;
        if (dout !== 32'h1234_5678) $display("FAIL data_hold got %h exp %h", dout, 32'h1234_5678);
        else pass_cnt++;
    endtask

    task automatic test_freeze();
        wr(2'd1, 32'h8765_4321);
        addr = 2'd1; #1;
        total_cnt++;
        if (dout !== 32'h0000_0001) $display("FAIL ctrl_freeze got %h exp %h", dout, 32'h1);
        else pass_cnt++;
        wr(2'd0, 32'h0);
        addr = 2'd0; #1;
        total_cnt++;
        if (dout !== 32'h1234_5678) $display("FAIL frozen_data got %h exp %h", dout, 32'h1234_5678);
        else pass_cnt++;
        wr(2'd3, 32'hDEAD_BEEF);
        addr = 2'd3; #1;
        total_cnt++;
        if (dout !== 32'hDEAD_BEEF) $display("FAIL scratch_while_frozen got %h exp %h", dout, 32'hDEAD_BEEF);
        else pass_cnt++;
    endtask

    task automatic test_clr_and_status_ro();
        logic [31:0] exp_cnt;
        // accepted so far: DATA, CTRL, SCRATCH, and this CTRL write
        exp_cnt = WCNT ? 32'd4 : 32'd0;
        wr(2'd1, 32'h0000_0002);
        addr = 2'd0; #1;
        total_cnt++;
        if (dout !== 32'h0) $display("FAIL clr_data got %h exp %h", dout, 32'h0);
        else pass_cnt++;
        addr = 2'd1; #1;
        total_cnt++;
        if (dout !== 32'h0) $display("FAIL clr_ctrl got %h exp %h", dout, 32'h0);
        else pass_cnt++;
        wr(2'd2, 32'hFFFF_FFFF);
        addr = 2'd2; #1;
        total_cnt++;
        if (dout !== exp_cnt) $display("FAIL status_ro got %h exp %h", dout, exp_cnt);
        else pass_cnt++;
        addr = 2'd3; #1;
        total_cnt++;
        if (dout !== 32'hDEAD_BEEF) $display("FAIL status_wr_side_effect got %h exp %h", dout, 32'hDEAD_BEEF);
        else pass_cnt++;
    endtask

    task automatic test_reset_priority();
        rst = 1'b1; en = 1'b1; addr = 2'd3; din = 32'hA5A5_A5A5;
        tick();
        rst = 1'b0; en = 1'b0;
        #1;
        total_cnt++;
        if (dout !== 32'h0) $display("FAIL rst_priority_scratch got %h exp %h", dout, 32'h0);
        else pass_cnt++;
        addr = 2'd2; #1;
        total_cnt++;
        if (dout !== 32'h0) $display("FAIL rst_priority_status got %h exp %h", dout, 32'h0);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_cnt;
        exp_cnt = WCNT ? 32'd3 : 32'd0;
        en = 1'b1;
        addr = 2'd0; din = 32'h1111_1111; tick();
        addr = 2'd3; din = 32'h2222_2222; tick();
        addr = 2'd1; din = 32'hFFFF_FFFD; tick();
        addr = 2'd2; din = 32'hFFFF_FFFF; tick();
        en = 1'b0;
        addr = 2'd2; #1;
        total_cnt++;
        if (dout !== exp_cnt) $display("FAIL wcnt got %h exp %h", dout, exp_cnt);
        else pass_cnt++;
        addr = 2'd0; #1;
        total_cnt++;
        if (dout !== 32'h1111_1111) $display("FAIL b2b_data got %h exp %h", dout, 32'h1111_1111);
        else pass_cnt++;
        addr = 2'd3; #1;
        total_cnt++;
        if (dout !== 32'h2222_2222) $display("FAIL b2b_scratch got %h exp %h", dout, 32'h2222_2222);
        else pass_cnt++;
        addr = 2'd1; #1;
        total_cnt++;
        if (dout !== 32'h0000_0001) $display("FAIL ctrl_upper_bits got %h exp %h", dout, 32'h1);
        else pass_cnt++;
        // frozen DATA write is neither stored nor counted
        wr(2'd0, 32'h3333_3333);
        addr = 2'd0; #1;
        total_cnt++;
        if (dout !== 32'h1111_1111) $display("FAIL frozen_data2 got %h exp %h", dout, 32'h1111_1111);
        else pass_cnt++;
        addr = 2'd2; #1;
        total_cnt++;
        if (dout !== exp_cnt) $display("FAIL wcnt_frozen got %h exp %h", dout, exp_cnt);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        rst = 1'b0; en = 1'b0; addr = 2'd0; din = 32'h0;
        test_reset();
        test_data_write();
        test_freeze();
        test_clr_and_status_ro();
        test_reset_priority();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
